wb_spider_arbiter: RTL and testbench

WB_SPIDER_ARBITER -- requirements
Module: wb_spider_arbiter

---
 rtl/wb_spider_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_spider_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spider_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared slave.
// Alternating priority on contention, whole-tenure grants, and a stall watchdog that forces an error.
module wb_spider_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk,
  input  logic              wb_rst,

  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int unsigned CW = 16;

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            gnt0, gnt1;
  logic            gnt_stb;
  logic            pend;
  logic            force_err;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // State, priority and watchdog registers.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stall_q <= stall_d;
    end
  end

  // Arbitration: a grant lasts as long as the owner keeps cyc high.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) state_d = IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts unanswered strobe cycles; a same-cycle slave response wins over the timeout.
  always_comb begin
    gnt_stb   = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
    pend      = gnt_stb & ~s_ack_i & ~s_err_i;
    force_err = pend & (stall_q == CW'(TIMEOUT - 1));
    stall_d   = (pend && !force_err) ? stall_q + CW'(1) : '0;
  end

  // Request mux toward the slave.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i & ~force_err;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i & ~force_err;
      end
      default: ;
    endcase
  end

  // Response routing: data is broadcast, handshakes go only to the owner.
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = gnt0 & s_ack_i;
  assign m1_ack_o  = gnt1 & s_ack_i;
  assign m0_err_o  = gnt0 & (s_err_i | force_err);
  assign m1_err_o  = gnt1 & (s_err_i | force_err);
  assign grant_o   = 2'(state_q);
  assign timeout_o = force_err;

endmodule

// File: tb/tb_wb_spider_arbiter.sv
// Bench for wb_spider_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_wb_spider_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i;
  logic          m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  wb_spider_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: current owner (-1 = nobody), most recent owner, and how many
  // consecutive cycles the owner's strobe has already gone unanswered.
  int own  = -1;
  int last = 1;
  int run  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_set(input int n, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    if (n == 0) begin
      m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d; m0_sel_i = sl;
    end else begin
      m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d; m1_sel_i = sl;
    end
  endtask

  // Compare all outputs against the model, then advance one clock (returns at the next negedge).
  task automatic tick();
    bit stb, pend, tmo;
    int nown, nlast, nrun;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    bit          e_we, e_cyc;
    if (wb_rst) begin
      own = -1; last = 1; run = 0;
    end
    stb  = (own == 0) ? m0_stb_i : (own == 1) ? m1_stb_i : 1'b0;
    pend = stb && !s_ack_i && !s_err_i;
    tmo  = pend && (run + 1 == TO);
    e_adr = (own == 0) ? m0_adr_i : (own == 1) ? m1_adr_i : 32'h0;
    e_dat = (own == 0) ? m0_dat_i : (own == 1) ? m1_dat_i : 32'h0;
    e_sel = (own == 0) ? m0_sel_i : (own == 1) ? m1_sel_i : 4'h0;
    e_we  = (own == 0) ? m0_we_i  : (own == 1) ? m1_we_i  : 1'b0;
    e_cyc = (own == 0) ? m0_cyc_i : (own == 1) ? m1_cyc_i : 1'b0;
    chk("grant",   64'(grant_o),   64'((own < 0) ? 0 : (1 << own)));
    chk("s_adr",   64'(s_adr_o),   64'(e_adr));
    chk("s_dat",   64'(s_dat_o),   64'(e_dat));
    chk("s_sel",   64'(s_sel_o),   64'(e_sel));
    chk("s_we",    64'(s_we_o),    64'(e_we));
    chk("s_cyc",   64'(s_cyc_o),   64'(e_cyc));
    chk("s_stb",   64'(s_stb_o),   64'(stb && !tmo));
    chk("m0_dat",  64'(m0_dat_o),  64'(s_dat_i));
    chk("m1_dat",  64'(m1_dat_o),  64'(s_dat_i));
    chk("m0_ack",  64'(m0_ack_o),  64'(own == 0 && s_ack_i));
    chk("m1_ack",  64'(m1_ack_o),  64'(own == 1 && s_ack_i));
    chk("m0_err",  64'(m0_err_o),  64'(own == 0 && (s_err_i || tmo)));
    chk("m1_err",  64'(m1_err_o),  64'(own == 1 && (s_err_i || tmo)));
    chk("timeout", 64'(timeout_o), 64'(tmo));
    nown = own; nlast = last;
    nrun = (pend && !tmo) ? run + 1 : 0;
    if (own < 0) begin
      if (m0_cyc_i && m1_cyc_i) nown = (last == 1) ? 0 : 1;
      else if (m0_cyc_i)        nown = 0;
      else if (m1_cyc_i)        nown = 1;
      if (nown >= 0) nlast = nown;
    end else if (!((own == 0) ? m0_cyc_i : m1_cyc_i)) begin
      nown = -1;
    end
    @(posedge wb_clk);
    if (!wb_rst) begin
      own = nown; last = nlast; run = nrun;
    end
    @(negedge wb_clk);
  endtask

  initial begin
    bit quiet;
    wb_rst = 1'b1;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    m_set(0, 0, 0, 0, 0, 0, 0);
    m_set(1, 0, 0, 0, 0, 0, 0);
    @(negedge wb_clk);
    #1; chk("reset_grant", 64'(grant_o), 64'(0));
    tick(); tick();
    wb_rst = 1'b0;
    #1; tick();

    // Single read by m0 with the slave answering on its second cycle.
    m_set(0, 1, 1, 0, 32'h0000_1000, 32'h0, 4'hF);
    #1; chk("r030_pre", 64'(grant_o), 64'(0)); tick();
    #1; chk("r030_gnt", 64'(grant_o), 64'(1)); chk("r030_adr", 64'(s_adr_o), 64'(32'h1000));
    chk("r030_noack", 64'(m0_ack_o), 64'(0)); tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1; chk("r030_dat", 64'(m0_dat_o), 64'(32'hDEAD_BEEF)); chk("r030_ack0", 64'(m0_ack_o), 64'(1));
    chk("r030_ack1", 64'(m1_ack_o), 64'(0)); tick();
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0);
    #1; chk("r030_hold", 64'(grant_o), 64'(1)); tick();
    #1; chk("r030_rel", 64'(grant_o), 64'(0)); tick();

    // Contention straight after reset: m0 first, one dead cycle, then m1.
    wb_rst = 1'b1; #1; tick(); wb_rst = 1'b0;
    m_set(0, 1, 1, 1, 32'h100, 32'hA0A0_A0A0, 4'hF);
    m_set(1, 1, 1, 1, 32'h200, 32'hB1B1_B1B1, 4'h3);
    #1; tick();
    s_ack_i = 1'b1;
    #1; chk("r031_first", 64'(grant_o), 64'(1)); chk("r031_m0ack", 64'(m0_ack_o), 64'(1));
    chk("r031_m1quiet", 64'(m1_ack_o), 64'(0)); tick();
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0);
    #1; tick();
    #1; chk("r031_dead", 64'(grant_o), 64'(0)); tick();
    s_ack_i = 1'b1;
    #1; chk("r031_second", 64'(grant_o), 64'(2)); chk("r031_m1ack", 64'(m1_ack_o), 64'(1));
    chk("r031_sdat", 64'(s_dat_o), 64'(32'hB1B1_B1B1)); tick();
    s_ack_i = 1'b0; m_set(1, 0, 0, 0, 0, 0, 0);
    #1; tick(); #1; tick();
    // A solo m0 write leaves m0 most recent, so the next contention goes to m1.
    m_set(0, 1, 1, 1, 32'h104, 32'h1, 4'hF);
    #1; tick(); s_ack_i = 1'b1; #1; tick();
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0); #1; tick(); #1; tick();
    m_set(0, 1, 1, 1, 32'h108, 32'h2, 4'hF);
    m_set(1, 1, 1, 1, 32'h208, 32'h3, 4'hF);
    #1; tick();
    s_ack_i = 1'b1;
    #1; chk("r031_repeat", 64'(grant_o), 64'(2)); chk("r031_rep_m0ack", 64'(m0_ack_o), 64'(0)); tick();
    s_ack_i = 1'b0; m_set(1, 0, 0, 0, 0, 0, 0);
    #1; tick(); #1; tick();
    s_ack_i = 1'b1;
    #1; chk("r031_rep_m0", 64'(grant_o), 64'(1)); tick();
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0); #1; tick(); #1; tick();

    // m1 burst of 4 beats while m0 waits.
    m_set(1, 1, 1, 0, 32'h300, 32'h0, 4'hF);
    #1; tick();
    m_set(0, 1, 1, 0, 32'h400, 32'h0, 4'hF);
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1; s_dat_i = 32'(b + 32'h50);
      #1; chk("r032_grant", 64'(grant_o), 64'(2)); chk("r032_m0ack", 64'(m0_ack_o), 64'(0));
      tick();
    end
    s_ack_i = 1'b0; m_set(1, 0, 0, 0, 0, 0, 0);
    #1; chk("r032_tail", 64'(grant_o), 64'(2)); tick();
    #1; chk("r032_dead", 64'(grant_o), 64'(0)); tick();
    #1; chk("r032_m0", 64'(grant_o), 64'(1)); s_ack_i = 1'b1; #1; tick();
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0); #1; tick(); #1; tick();

    // Silent slave: the forced error lands in the TO-th stalled cycle.
    m_set(0, 1, 1, 0, 32'h500, 32'h0, 4'hF);
    #1; tick();
    for (int k = 1; k <= TO; k++) begin
      #1;
      if (k < TO) begin
        chk("r033_notyet", 64'(timeout_o), 64'(0)); chk("r033_stb", 64'(s_stb_o), 64'(1));
      end else begin
        chk("r033_err", 64'(m0_err_o), 64'(1)); chk("r033_tmo", 64'(timeout_o), 64'(1));
        chk("r033_stb_low", 64'(s_stb_o), 64'(0));
      end
      tick();
    end
    m_set(0, 0, 0, 0, 0, 0, 0); #1; tick(); #1; tick();

    // Ack in the would-be timeout cycle wins.
    m_set(0, 1, 1, 0, 32'h600, 32'h0, 4'hF);
    #1; tick();
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) s_ack_i = 1'b1;
      #1;
      if (k == TO) begin
        chk("r034_ack", 64'(m0_ack_o), 64'(1)); chk("r034_noerr", 64'(m0_err_o), 64'(0));
        chk("r034_notmo", 64'(timeout_o), 64'(0));
      end
      tick();
    end
    s_ack_i = 1'b0; m_set(0, 0, 0, 0, 0, 0, 0); #1; tick(); #1; tick();

    // Reset mid-tenure between edges; m0 was most recent, yet wins afterwards.
    m_set(0, 1, 1, 0, 32'h700, 32'h0, 4'hF);
    #1; tick();
    #1; chk("r035_gnt", 64'(grant_o), 64'(1)); tick();
    #2; wb_rst = 1'b1; m_set(1, 1, 1, 0, 32'h800, 32'h0, 4'hF);
    #1; chk("r035_async_gnt", 64'(grant_o), 64'(0)); chk("r035_async_cyc", 64'(s_cyc_o), 64'(0));
    tick(); #1; tick();
    wb_rst = 1'b0;
    #1; chk("r035_idle", 64'(grant_o), 64'(0)); tick();
    #1; chk("r035_m0wins", 64'(grant_o), 64'(1)); tick();
    m_set(0, 0, 0, 0, 0, 0, 0); m_set(1, 0, 0, 0, 0, 0, 0);
    #1; tick(); #1; tick();

    // Random traffic with alternating responsive and silent slave phases.
    quiet = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) quiet = ~quiet;
      for (int n = 0; n < 2; n++) begin
        logic cy;
        cy = (n == 0) ? m0_cyc_i : m1_cyc_i;
        if ($urandom_range(0, 5) == 0) cy = ~cy;
        m_set(n, cy, cy && ($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
              4'($urandom));
      end
      s_dat_i = $urandom;
      s_ack_i = !quiet && ($urandom_range(0, 9) < 3);
      s_err_i = !quiet && ($urandom_range(0, 19) == 0);
      wb_rst  = ($urandom_range(0, 199) == 0);
      #1; tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
